// File: rtl/decoder_rx_sm_if.sv
// rtl/decoder_rx_sm_if.sv - PAM5 symbol vector handshake between trellis decoder and PCS receive FSM
interface decoder_rx_sm_if;
   logic       io_rx_symb_vector_valid;
   logic       io_rx_symb_vector_ready;
   logic [2:0] io_rx_symb_vector_bits_0;
   logic [2:0] io_rx_symb_vector_bits_1;
   logic [2:0] io_rx_symb_vector_bits_2;
   logic [2:0] io_rx_symb_vector_bits_3;
   logic [7:0] io_decoded_rx_symb_vector;

   modport master (
      output io_rx_symb_vector_valid,
      output io_rx_symb_vector_bits_0,
      output io_rx_symb_vector_bits_1,
      output io_rx_symb_vector_bits_2,
      output io_rx_symb_vector_bits_3,
      output io_decoded_rx_symb_vector,
      input  io_rx_symb_vector_ready
   );

   modport slave (
      input  io_rx_symb_vector_valid,
      input  io_rx_symb_vector_bits_0,
      input  io_rx_symb_vector_bits_1,
      input  io_rx_symb_vector_bits_2,
      input  io_rx_symb_vector_bits_3,
      input  io_decoded_rx_symb_vector,
      output io_rx_symb_vector_ready
   );
endinterface

// File: rtl/decoder_rx_sm.sv
// rtl/decoder_rx_sm.sv - 1000BASE-T PCS receive delimiter detection and GMII-style decode FSM
module decoder_rx_sm #(
   parameter int MAX_FRAME = 2048,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_loc_rcvr_status,
   decoder_rx_sm_if.slave       rx,
   input  logic                 io_err_clear,
   output logic [7:0]           io_rxd,
   output logic                 io_rx_dv,
   output logic                 io_rx_er,
   output logic                 io_rxerror_status,
   output logic [ERR_CNT_W-1:0] io_err_count
);

   localparam int CNT_W = $clog2(MAX_FRAME + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SSD1_SEEN,
      S_RECEIVE,
      S_ESD_CHECK,
      S_WAIT_IDLE
   } state_t;

   state_t               state_q, state_next;
   logic                 ready_q;
   logic [7:0]           rxd_next;
   logic                 dv_next, er_next, stat_next;
   logic [CNT_W-1:0]     cnt_q, cnt_next;
   logic [ERR_CNT_W-1:0] err_cnt_next;

   logic [2:0] comp [4];
   logic [3:0] comp_p2, comp_m2, comp_zero, comp_one;
   logic       any_invalid, is_ssd1, is_ssd2, idle_class, is_data, accept;

   assign comp[0] = rx.io_rx_symb_vector_bits_0;
   assign comp[1] = rx.io_rx_symb_vector_bits_1;
   assign comp[2] = rx.io_rx_symb_vector_bits_2;
   assign comp[3] = rx.io_rx_symb_vector_bits_3;

   always_comb begin
      comp_p2   = '0;
      comp_m2   = '0;
      comp_zero = '0;
      comp_one  = '0;
      for (int i = 0; i < 4; i++) begin
         comp_p2[i]   = (comp[i] == 3'b010);
         comp_m2[i]   = (comp[i] == 3'b110);
         comp_zero[i] = (comp[i] == 3'b000);
         comp_one[i]  = (comp[i] == 3'b001) || (comp[i] == 3'b111);
      end
   end

   // SSD1 and ESD1 share one code, as do SSD2 and ESD2; the FSM state tells them apart.
   assign any_invalid = ~&(comp_p2 | comp_m2 | comp_zero | comp_one);
   assign is_ssd1     = &comp_p2;
   assign is_ssd2     = &comp_p2[2:0] & comp_m2[3];
   assign idle_class  = &(comp_p2 | comp_m2 | comp_zero) & ~is_ssd1;
   assign is_data     = ~any_invalid & |comp_one;

   assign accept                     = rx.io_rx_symb_vector_valid & ready_q;
   assign rx.io_rx_symb_vector_ready = ready_q;

   always_comb begin
      state_next = state_q;
      rxd_next   = io_rxd;
      dv_next    = io_rx_dv;
      er_next    = 1'b0;
      cnt_next   = cnt_q;
      if (!io_loc_rcvr_status) begin
         state_next = S_IDLE;
         rxd_next   = 8'h00;
         dv_next    = 1'b0;
         cnt_next   = '0;
      end else if (accept) begin
         case (state_q)
            S_IDLE: begin
               rxd_next = 8'h00;
               dv_next  = 1'b0;
               if (is_ssd1) state_next = S_SSD1_SEEN;
            end
            S_SSD1_SEEN: begin
               if (is_ssd2) begin
                  state_next = S_RECEIVE;
                  dv_next    = 1'b1;
                  rxd_next   = 8'h55;
                  cnt_next   = '0;
               end else begin
                  state_next = S_WAIT_IDLE;
                  dv_next    = 1'b0;
                  er_next    = 1'b1;
                  rxd_next   = 8'h0E;
               end
            end
            S_RECEIVE: begin
               if (any_invalid || is_data) begin
                  dv_next = 1'b1;
                  // Jabber check wins over a corrupted symbol on the overflowing vector.
                  if (cnt_q == CNT_W'(MAX_FRAME)) begin
                     state_next = S_WAIT_IDLE;
                     er_next    = 1'b1;
                     rxd_next   = 8'h00;
                  end else begin
                     er_next  = any_invalid;
                     rxd_next = rx.io_decoded_rx_symb_vector;
                     cnt_next = cnt_q + 1'b1;
                  end
               end else if (is_ssd1) begin
                  state_next = S_ESD_CHECK;
                  dv_next    = 1'b0;
               end else begin
                  state_next = S_IDLE;
                  dv_next    = 1'b1;
                  er_next    = 1'b1;
                  rxd_next   = 8'h00;
               end
            end
            S_ESD_CHECK: begin
               state_next = S_IDLE;
               dv_next    = 1'b0;
               if (!is_ssd2) begin
                  er_next  = 1'b1;
                  rxd_next = 8'h00;
               end
            end
            S_WAIT_IDLE: begin
               dv_next = 1'b0;
               if (idle_class) state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
               dv_next    = 1'b0;
               rxd_next   = 8'h00;
            end
         endcase
      end
   end

   always_comb begin
      stat_next    = er_next ? 1'b1 : (io_err_clear ? 1'b0 : io_rxerror_status);
      err_cnt_next = io_err_count;
      if (er_next && !(&io_err_count)) err_cnt_next = io_err_count + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         ready_q           <= 1'b0;
         cnt_q             <= '0;
         io_rxd            <= 8'h00;
         io_rx_dv          <= 1'b0;
         io_rx_er          <= 1'b0;
         io_rxerror_status <= 1'b0;
         io_err_count      <= '0;
      end else begin
         state_q           <= state_next;
         ready_q           <= 1'b1;
         cnt_q             <= cnt_next;
         io_rxd            <= rxd_next;
         io_rx_dv          <= dv_next;
         io_rx_er          <= er_next;
         io_rxerror_status <= stat_next;
         io_err_count      <= err_cnt_next;
      end
   end

endmodule

// File: doc/decoder_rx_sm.md
Name: decoder_rx_sm

Overview:
- 1000BASE-T PCS receive-side delimiter and decode state machine; the receive-direction counterpart of the PCS transmit encoder.
- Consumes one 4D PAM5 symbol vector per accepted handshake, plus the byte that the upstream trellis/Viterbi path has already decoded for that vector.
- Detects SSD/ESD delimiters and produces GMII-style io_rxd/io_rx_dv/io_rx_er, a sticky error flag and a saturating error counter.

Parameters:
MAX_FRAME, 2048, max data vectors in RECEIVE before jabber abort
ERR_CNT_W, 16, width of io_err_count

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clock
io_loc_rcvr_status  input  1  1 = local receiver OK; 0 forces IDLE
io_rx_symb_vector_valid  input  1  symbol vector valid
io_rx_symb_vector_ready  output  1  block accepts vector
io_rx_symb_vector_bits_0..3  input  3 each  PAM5 components A..D, 3-bit two's complement
io_decoded_rx_symb_vector  input  8  decoded byte aligned with current vector
io_err_clear  input  1  clears io_rxerror_status
io_rxd  output  8  receive data
io_rx_dv  output  1  data valid
io_rx_er  output  1  receive error
io_rxerror_status  output  1  sticky error flag
io_err_count  output  ERR_CNT_W  saturating count of cycles with io_rx_er=1

Behaviour:
- Reset (reset=0): state IDLE; io_rxd=0, io_rx_dv=0, io_rx_er=0, io_rxerror_status=0, io_err_count=0, io_rx_symb_vector_ready=0, data counter=0.
- After reset release: io_rx_symb_vector_ready=1 on every cycle. The block never backpressures.
- An accept is valid&ready. All outputs are registered and update 1 cycle after an accept.
- With no accept, io_rxd and io_rx_dv hold their values; io_rx_er is forced to 0.
- Symbol classes, decoded per component:
  - 3'b010 = +2, 3'b001 = +1, 3'b000 = 0, 3'b111 = -1, 3'b110 = -2.
  - Codes 011, 100 and 101 are INVALID.
  - SSD1/ESD1 = (+2,+2,+2,+2). SSD2 = (+2,+2,+2,-2). ESD2 = (+2,+2,+2,-2).
  - IDLE-class: all components in {-2,0,+2} and not (+2,+2,+2,+2).
  - DATA: all components valid, at least one ±1.
- States and transitions (evaluated on accept):
  - IDLE:
    - SSD1 -> SSD1_SEEN.
    - Anything else -> stay.
    - Outputs dv=0, er=0, rxd=0.
  - SSD1_SEEN:
    - SSD2 -> RECEIVE; dv=1, rxd=8'h55.
    - Else -> WAIT_IDLE with false carrier: er=1, dv=0, rxd=8'h0E.
  - RECEIVE:
    - DATA -> dv=1, rxd=io_decoded_rx_symb_vector; data counter+1.
    - ESD1 -> ESD_CHECK; dv=0, er=0.
    - Other IDLE-class -> IDLE with premature end: dv=1, er=1, rxd=0.
    - Any INVALID component -> stay; dv=1, er=1, rxd=decoded byte, counter+1.
  - ESD_CHECK:
    - ESD2 -> IDLE; dv=0, er=0.
    - Else -> IDLE; er=1, dv=0, rxd=0.
  - WAIT_IDLE:
    - IDLE-class -> IDLE.
    - Else stay; dv=0, er=0.
- Jabber: when the RECEIVE accept would make the data counter exceed MAX_FRAME, emit dv=1, er=1, rxd=0 and go to WAIT_IDLE. The counter clears on entry to RECEIVE.
- io_loc_rcvr_status=0: synchronously forces IDLE with dv=0, er=0, rxd=0, counter=0. It takes priority over any accept that cycle and does not count as an error.
- io_rxerror_status: set on any cycle where io_rx_er goes 1. io_err_clear clears it. If a set and a clear occur in the same cycle, set wins.
- io_err_count: +1 per cycle with io_rx_er=1; saturates at all-ones and does not wrap.
- Asserting reset mid-frame: all state and outputs return to reset values immediately (asynchronous).

Test Plan:
1. Reset, status=1, valid=1 with idles (0,+2,-2,0) x3, then SSD1, SSD2, data vectors (+1,0,0,0) with decoded bytes 0x00..0x03, then ESD1, ESD2 -> rxd 0x55, 0x00, 0x01, 0x02, 0x03 with dv=1 on 5 consecutive cycles; dv=0 after ESD1; er never 1; err_count=0.
2. SSD1 followed by idle (0,0,0,0) -> one cycle er=1, rxd=0x0E, dv=0; state stays WAIT_IDLE until an idle vector arrives; err_count=1; rxerror_status=1.
3. In RECEIVE, send idle (0,+2,0,-2) -> one cycle dv=1, er=1, rxd=0x00; next cycle dv=0; return to IDLE. Then assert err_clear together with a new false carrier -> rxerror_status stays 1.
4. MAX_FRAME=4, send 6 data vectors -> 4 clean bytes, 5th gives dv=1, er=1, rxd=0; the 6th data vector is ignored (WAIT_IDLE, dv=0).
5. Mid-frame: drop loc_rcvr_status for 1 cycle -> dv=0, er=0 next cycle; err_count unchanged. Then drive reset=0 asynchronously between clock edges -> all outputs 0 before the next edge.
6. ESD1 then (-2,+2,+2,+2) -> er=1 pulse, dv=0; ERR_CNT_W=2 with 5 error events -> err_count saturates at 3.
